// File: rtl/alu_z_stage.sv
// rtl/alu_z_stage.sv - ALU result capture into the Z pair with zero/negative flags, drain tracking and multi-cycle timeout
module alu_z_stage #(
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 64
) (
    input  logic              clock,
    input  logic              clear_n,
    input  logic              start,
    input  logic              multicycle,
    input  logic [DATA_W-1:0] comb_result,
    input  logic              mc_done,
    input  logic [DATA_W-1:0] mc_hi,
    input  logic [DATA_W-1:0] mc_lo,
    input  logic              read_hi,
    input  logic              read_lo,
    output logic [DATA_W-1:0] z_hi,
    output logic [DATA_W-1:0] z_lo,
    output logic              valid,
    output logic              busy,
    output logic              zero_flag,
    output logic              neg_flag,
    output logic              timeout_err
);

    localparam int CNT_W = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_FULL = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt;
    logic [DATA_W-1:0] r_z_hi;
    logic [DATA_W-1:0] w_z_hi;
    logic [DATA_W-1:0] r_z_lo;
    logic [DATA_W-1:0] w_z_lo;
    logic              r_zero;
    logic              w_zero;
    logic              r_neg;
    logic              w_neg;
    logic              r_terr;
    logic              w_terr;
    logic              r_rd_hi;
    logic              w_rd_hi;
    logic              r_rd_lo;
    logic              w_rd_lo;
    logic              r_valid;
    logic              r_busy;
    logic              w_accept;
    logic              w_hi_drained;
    logic              w_lo_drained;

    assign w_hi_drained = r_rd_hi | read_hi;
    assign w_lo_drained = r_rd_lo | read_lo;

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_z_hi  <= '0;
            r_z_lo  <= '0;
            r_zero  <= 1'b0;
            r_neg   <= 1'b0;
            r_terr  <= 1'b0;
            r_rd_hi <= 1'b0;
            r_rd_lo <= 1'b0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state;
            r_cnt   <= w_cnt;
            r_z_hi  <= w_z_hi;
            r_z_lo  <= w_z_lo;
            r_zero  <= w_zero;
            r_neg   <= w_neg;
            r_terr  <= w_terr;
            r_rd_hi <= w_rd_hi;
            r_rd_lo <= w_rd_lo;
            r_valid <= (w_state == S_FULL);
            r_busy  <= (w_state == S_WAIT);
        end
    end

    always_comb begin
        w_state  = r_state;
        w_cnt    = r_cnt;
        w_z_hi   = r_z_hi;
        w_z_lo   = r_z_lo;
        w_zero   = r_zero;
        w_neg    = r_neg;
        w_terr   = r_terr;
        w_rd_hi  = r_rd_hi;
        w_rd_lo  = r_rd_lo;
        w_accept = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_accept = start;
            end
            S_WAIT: begin
                // mc_done is checked first so it wins over a coincident timeout
                if (mc_done) begin
                    w_z_hi  = mc_hi;
                    w_z_lo  = mc_lo;
                    w_neg   = mc_hi[DATA_W-1];
                    w_zero  = (mc_hi == '0) && (mc_lo == '0);
                    w_rd_hi = 1'b0;
                    w_rd_lo = 1'b0;
                    w_state = S_FULL;
                end else if (r_cnt == CNT_LAST) begin
                    w_terr  = 1'b1;
                    w_state = S_IDLE;
                end else begin
                    w_cnt = r_cnt + 1'b1;
                end
            end
            S_FULL: begin
                if (start) begin
                    w_accept = 1'b1;
                end else if (w_hi_drained && w_lo_drained) begin
                    w_rd_hi = 1'b0;
                    w_rd_lo = 1'b0;
                    w_state = S_IDLE;
                end else begin
                    w_rd_hi = w_hi_drained;
                    w_rd_lo = w_lo_drained;
                end
            end
            default: begin
                w_state = S_IDLE;
            end
        endcase

        if (w_accept) begin
            w_rd_hi = 1'b0;
            w_rd_lo = 1'b0;
            if (multicycle) begin
                w_cnt   = '0;
                w_terr  = 1'b0;
                w_state = S_WAIT;
            end else begin
                // single-cycle results are zero-extended into the pair
                w_z_hi  = '0;
                w_z_lo  = comb_result;
                w_neg   = comb_result[DATA_W-1];
                w_zero  = (comb_result == '0);
                w_state = S_FULL;
            end
        end
    end

    assign z_hi        = r_z_hi;
    assign z_lo        = r_z_lo;
    assign valid       = r_valid;
    assign busy        = r_busy;
    assign zero_flag   = r_zero;
    assign neg_flag    = r_neg;
    assign timeout_err = r_terr;

endmodule

// File: doc/alu_z_stage.md
# alu_z_stage

Result-capture stage that sits directly downstream of the ALU operation units: rotate/shift/logic units and the sequential multiply/divide units. Latches each operation's result into the 64-bit Z pair (z_hi/z_lo) and derives zero/negative flags. Holds the result valid until the datapath bus has drained both halves, and guards multi-cycle operations with a timeout.

## Interface

- DATA_W, 32, width of one Z half and of every ALU operand/result
- TIMEOUT, 64, maximum cycles allowed in the multi-cycle wait state before abort (≥2)

Ports:

- clock  in  1  rising-edge clock
- clear_n  in  1  reset, asynchronous assert, active-low
- start  in  1  one-cycle pulse: an ALU operation issues this cycle
- multicycle  in  1  sampled with start; 1 = result arrives later via mc_done
- comb_result  in  DATA_W  single-cycle unit result, valid in the start cycle
- mc_done  in  1  multi-cycle unit result valid this cycle
- mc_hi, mc_lo  in  DATA_W  multi-cycle result halves, valid with mc_done
- read_hi, read_lo  in  1  bus drains z_hi / z_lo this cycle
- z_hi, z_lo  out  DATA_W  captured result
- valid  out  1  Z holds an unread result
- busy  out  1  multi-cycle operation pending
- zero_flag  out  1  captured 64-bit result equals 0
- neg_flag  out  1  sign of captured result
- timeout_err  out  1  sticky: last multi-cycle operation timed out

## Operation

- States: IDLE, WAIT, FULL. Reset enters IDLE; all outputs 0; counter 0; read-tracking bits 0.
- IDLE, start & !multicycle:
  - z_lo ← comb_result, z_hi ← 0; go FULL.
  - neg_flag ← comb_result[DATA_W-1]; zero_flag ← (comb_result == 0).
- IDLE, start & multicycle: clear counter and timeout_err; go WAIT.
- WAIT:
  - busy=1; counter increments each cycle.
  - mc_done: z_hi ← mc_hi, z_lo ← mc_lo; neg_flag ← mc_hi[DATA_W-1]; zero_flag ← both halves 0; go FULL.
  - No mc_done by counter = TIMEOUT-1: timeout_err ← 1, z unchanged, go IDLE.
  - mc_done wins if it coincides with the timeout cycle.
  - start ignored in WAIT.
- FULL:
  - valid=1; read_hi/read_lo set per-half "drained" bits.
  - Return to IDLE on the edge where both bits are set; both halves may be read in the same cycle, or in either order.
  - z and flags are retained after drain; only valid drops.
- start in FULL: new operation accepted as from IDLE (overwrite for single-cycle, WAIT for multi-cycle). Drained bits clear. A start coinciding with the final read takes priority.
- Reads with valid=0 are ignored. mc_done outside WAIT is ignored.
- timeout_err clears only on the next multicycle start or on reset.
- Single-cycle results are zero-extended, never sign-extended, into the pair.

## Timing

- Single-cycle op: start sampled at edge N; z_lo/flags/valid visible after edge N. Latency 1.
- Multi-cycle op: busy rises after the start edge. Results and valid are visible after the edge sampling mc_done; busy falls on that same edge.
- Timeout: with start at edge N, busy falls and timeout_err rises after edge N+TIMEOUT, if mc_done was never sampled.
- Drain: valid falls after the edge on which the second half is read.
- Back-to-back single-cycle ops (start every cycle) capture every cycle; valid stays 1.
- Asynchronous clear_n assertion mid-WAIT or mid-FULL forces IDLE and zeroes outputs immediately, with no clock edge required. Deassertion is assumed synchronous to the clock by the upstream reset synchroniser.
- All outputs are registered; no combinational path from inputs to outputs.

## Test plan

- Single-cycle capture: start, multicycle=0, comb_result=0x0000_0003 (0x8000_0001 rotated left 1) → next cycle z_lo=0x0000_0003, z_hi=0, valid=1, zero_flag=0, neg_flag=0.
- Multi-cycle capture: start, multicycle=1; mc_done 5 cycles later with mc_hi=0xFFFF_FFFF, mc_lo=0xFFFF_FFFE → busy=1 for 5 cycles, then z={0xFFFF_FFFF,0xFFFF_FFFE}, neg_flag=1, valid=1, busy=0.
- Drain ordering:
  - read_lo then read_hi two cycles later → valid stays 1 until after the read_hi edge.
  - Repeat with both reads in the same cycle → valid=0 the next cycle.
- Timeout (TIMEOUT=64): multicycle start, no mc_done → busy falls and timeout_err=1 after edge 64. A late mc_done is ignored. The next multicycle start clears timeout_err.
- Zero result and overwrite:
  - comb_result=0 → zero_flag=1.
  - While valid and undrained, start with comb_result=0x8000_0000 → z_lo=0x8000_0000, neg_flag=1, zero_flag=0, valid stays 1.
- Reset mid-operation: clear_n low 3 cycles into WAIT → all outputs 0 immediately, state IDLE. After release, a single-cycle start behaves normally.
